// File: rtl/pipe_stage_chain.sv
// Pipeline-register chain carrying payload plus valid/we/rd metadata through STAGES
// registers, with global stall, per-stage bubble insertion, retire counting and forwarding lookup.
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int RD_W   = 5,
    localparam int SEL_W = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic [STAGES-1:0]        flush_mask,
    input  logic                     in_valid,
    input  logic                     in_we,
    input  logic [RD_W-1:0]          in_rd,
    input  logic [WIDTH-1:0]         in_data,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES-1:0]        stage_we,
    output logic [STAGES*RD_W-1:0]   stage_rd,
    output logic [STAGES*WIDTH-1:0]  stage_data,
    input  logic [RD_W-1:0]          q_rs,
    output logic                     q_hit,
    output logic [SEL_W-1:0]         q_stage,
    output logic [WIDTH-1:0]         q_data,
    output logic [SEL_W:0]           occupancy,
    output logic [31:0]              retired
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] we_q;
    logic [RD_W-1:0]   rd_q   [STAGES];
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [31:0]       retired_q;

    logic [STAGES-1:0] valid_src;
    logic [STAGES-1:0] we_src;
    logic [RD_W-1:0]   rd_src   [STAGES];
    logic [WIDTH-1:0]  data_src [STAGES];
    logic [STAGES-1:0] valid_d;

    // Source selection: shift on advance, self-hold on stall.
    always_comb begin
        valid_src[0] = stall ? valid_q[0] : in_valid;
        we_src[0]    = stall ? we_q[0]    : in_we;
        rd_src[0]    = stall ? rd_q[0]    : in_rd;
        data_src[0]  = stall ? data_q[0]  : in_data;
        for (int k = 1; k < STAGES; k++) begin
            valid_src[k] = stall ? valid_q[k] : valid_q[k-1];
            we_src[k]    = stall ? we_q[k]    : we_q[k-1];
            rd_src[k]    = stall ? rd_q[k]    : rd_q[k-1];
            data_src[k]  = stall ? data_q[k]  : data_q[k-1];
        end
        // Flush only kills validity; rd/we/data ride along untouched.
        valid_d = valid_src & ~flush_mask;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q   <= '0;
            we_q      <= '0;
            retired_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                rd_q[k]   <= '0;
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            we_q    <= we_src;
            for (int k = 0; k < STAGES; k++) begin
                rd_q[k]   <= rd_src[k];
                data_q[k] <= data_src[k];
            end
            // The leaving entry counts even if the last stage is flushed this edge.
            if (!stall && valid_q[STAGES-1]) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    always_comb begin
        stage_valid = valid_q;
        stage_we    = valid_q & we_q;
        stage_rd    = '0;
        stage_data  = '0;
        occupancy   = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_rd[k*RD_W +: RD_W]    = rd_q[k];
            stage_data[k*WIDTH +: WIDTH] = data_q[k];
            occupancy = occupancy + {{SEL_W{1'b0}}, valid_q[k]};
        end
    end

    // Scan oldest to youngest so the youngest (lowest index) match wins.
    always_comb begin
        q_hit   = 1'b0;
        q_stage = '0;
        q_data  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (valid_q[k] && we_q[k] && (rd_q[k] == q_rs) && (q_rs != '0)) begin
                q_hit   = 1'b1;
                q_stage = SEL_W'(k);
                q_data  = data_q[k];
            end
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed + randomized bench for pipe_stage_chain, compared against an array-based
// reference pipeline kept in the bench.
module tb_pipe_stage_chain;
    localparam int W  = 32;
    localparam int S  = 3;
    localparam int R  = 5;
    localparam int SW = 2;

    logic           clk;
    logic           reset;
    logic           stall;
    logic [S-1:0]   flush_mask;
    logic           in_valid;
    logic           in_we;
    logic [R-1:0]   in_rd;
    logic [W-1:0]   in_data;
    logic [S-1:0]   stage_valid;
    logic [S-1:0]   stage_we;
    logic [S*R-1:0] stage_rd;
    logic [S*W-1:0] stage_data;
    logic [R-1:0]   q_rs;
    logic           q_hit;
    logic [SW-1:0]  q_stage;
    logic [W-1:0]   q_data;
    logic [SW:0]    occupancy;
    logic [31:0]    retired;

    pipe_stage_chain #(.WIDTH(W), .STAGES(S), .RD_W(R)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush_mask(flush_mask),
        .in_valid(in_valid), .in_we(in_we), .in_rd(in_rd), .in_data(in_data),
        .stage_valid(stage_valid), .stage_we(stage_we), .stage_rd(stage_rd),
        .stage_data(stage_data), .q_rs(q_rs), .q_hit(q_hit), .q_stage(q_stage),
        .q_data(q_data), .occupancy(occupancy), .retired(retired)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference pipeline: slot k holds the entry that has spent k+1 edges in the chain.
    logic         mv  [S];
    logic         mwe [S];
    logic [R-1:0] mrd [S];
    logic [W-1:0] md  [S];
    logic [31:0]  mret;
    logic [W-1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [S-1:0]   ev, ewe;
        logic [S*R-1:0] erd;
        logic [S*W-1:0] edata;
        logic [SW:0]    eocc;
        logic           ehit;
        logic [SW-1:0]  eqs;
        logic [W-1:0]   eqd;
        ev = '0; ewe = '0; erd = '0; edata = '0; eocc = '0;
        ehit = 1'b0; eqs = '0; eqd = '0;
        for (int k = 0; k < S; k++) begin
            ev[k]  = mv[k];
            ewe[k] = mv[k] & mwe[k];
            erd[k*R +: R]   = mrd[k];
            edata[k*W +: W] = md[k];
            eocc = eocc + (mv[k] ? 1 : 0);
        end
        for (int k = 0; k < S; k++) begin
            if (!ehit && ewe[k] && mrd[k] == q_rs && q_rs != 0) begin
                ehit = 1'b1;
                eqs  = SW'(k);
                eqd  = md[k];
            end
        end
        chk({tag, ".valid"}, stage_valid, ev);
        chk({tag, ".we"}, stage_we, ewe);
        chk({tag, ".rd"}, stage_rd, erd);
        chk({tag, ".data"}, stage_data, edata);
        chk({tag, ".occupancy"}, occupancy, eocc);
        chk({tag, ".retired"}, retired, mret);
        chk({tag, ".q_hit"}, q_hit, ehit);
        chk({tag, ".q_stage"}, q_stage, eqs);
        chk({tag, ".q_data"}, q_data, eqd);
    endtask

    // Driver tasks
    task automatic drive(input logic v, input logic we, input logic [R-1:0] rd,
                         input logic [W-1:0] d, input logic st, input logic [S-1:0] fm);
        in_valid   = v;
        in_we      = we;
        in_rd      = rd;
        in_data    = d;
        stall      = st;
        flush_mask = fm;
    endtask

    task automatic tick(input string tag);
        logic         obs_last_v;
        logic [W-1:0] obs_last_d;
        logic [W-1:0] e;
        obs_last_v = stage_valid[S-1];
        obs_last_d = stage_data[(S-1)*W +: W];
        if (!reset) begin
            for (int k = 0; k < S; k++) begin
                mv[k] = 0; mwe[k] = 0; mrd[k] = '0; md[k] = '0;
            end
            mret = '0;
        end else begin
            if (!stall && mv[S-1]) begin
                mret = mret + 1;
                exp_q.push_back(md[S-1]);
            end
            if (!stall) begin
                for (int k = S - 1; k > 0; k--) begin
                    mv[k] = mv[k-1]; mwe[k] = mwe[k-1]; mrd[k] = mrd[k-1]; md[k] = md[k-1];
                end
                mv[0] = in_valid; mwe[0] = in_we; mrd[0] = in_rd; md[0] = in_data;
            end
            for (int k = 0; k < S; k++) begin
                if (flush_mask[k]) mv[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ".retire_valid"}, obs_last_v, 1'b1);
            chk({tag, ".retire_data"}, obs_last_d, e);
        end
        check_all(tag);
    endtask

    task automatic query(input string tag, input logic [R-1:0] rs);
        q_rs = rs;
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0;
        q_rs  = '0;
        for (int k = 0; k < S; k++) begin
            mv[k] = 1; mwe[k] = 1; mrd[k] = '1; md[k] = '1;
        end
        mret = 32'hdead_beef;

        // Reset dominates stall and a valid input.
        drive(1, 1, 5'd3, 32'h1234, 1, '1);
        tick("rst0");
        tick("rst1");
        chk("rst.occupancy_zero", occupancy, 0);

        // Fill A, B, C then drain one.
        reset = 1'b1;
        drive(1, 1, 5'd1, 32'hA, 0, '0); tick("fill_a");
        drive(1, 1, 5'd2, 32'hB, 0, '0); tick("fill_b");
        drive(1, 1, 5'd3, 32'hC, 0, '0); tick("fill_c");
        chk("fill.layout", stage_data, {32'hA, 32'hB, 32'hC});
        chk("fill.occ3", occupancy, 3);
        drive(0, 0, 5'd0, 32'h0, 0, '0); tick("drain");
        chk("drain.retired1", retired, 1);
        chk("drain.occ2", occupancy, 2);

        // Refill, then hold under stall; a stalled flush only clears stage 1.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, R'(i + 4), W'($urandom), 0, '0);
            tick("refill");
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 5'd9, W'($urandom), 1, '0);
            tick("stall_hold");
        end
        drive(1, 1, 5'd9, 32'h0, 1, 3'b010); tick("stall_flush");

        // Stages 0 and 2 both write r5; youngest wins.
        reset = 1'b0; tick("rst_fwd"); reset = 1'b1;
        drive(1, 1, 5'd5, 32'h22, 0, '0); tick("fwd_old");
        drive(0, 0, 5'd0, 32'h0, 0, '0);  tick("fwd_gap");
        drive(1, 1, 5'd5, 32'h11, 0, '0); tick("fwd_young");
        query("fwd_q5", 5'd5);
        chk("fwd.stage0", q_stage, 0);
        chk("fwd.data11", q_data, 32'h11);
        query("fwd_q7", 5'd7);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'd0, W'($urandom), 0, '0);
            tick("rd0_fill");
        end
        query("fwd_q0", 5'd0);
        chk("fwd.r0_nohit", q_hit, 0);

        // Advancing flush on stage 0 inserts a bubble while old stage 0 moves on.
        drive(1, 1, 5'd6, 32'h66, 0, 3'b001); tick("flush_adv");

        // Random traffic with small rd range so matches are frequent.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), R'($urandom_range(0, 3)),
                  W'($urandom), ($urandom_range(0, 3) == 0), S'($urandom_range(0, 7) & 
                  (($urandom_range(0, 2) == 0) ? 7 : 0)));
            q_rs = R'($urandom_range(0, 3));
            tick("rand");
        end

        // Retire counter wrap from all-ones, then mid-stream reset.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'd1, W'($urandom), 0, '0);
            tick("wrap_fill");
        end
        dut.retired_q = 32'hFFFF_FFFF;
        mret = 32'hFFFF_FFFF;
        drive(1, 1, 5'd1, 32'h77, 0, '0); tick("wrap");
        chk("wrap.zero", retired, 0);
        drive(1, 1, 5'd2, 32'h88, 0, '0); tick("post_wrap");
        reset = 1'b0;
        drive(1, 1, 5'd2, 32'h99, 0, '0); tick("mid_rst");
        chk("mid_rst.occ0", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
